// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - instruction-fetch stage with req/ack imem port and IF/ID register
// Holds the PC, fetches one word per request, applies ID redirects/stalls, inserts bubbles.
module pipe_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [2:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] Dpc4,
   output logic [31:0] Dinst,
   output logic        Dvalid
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] ibuf_q, ibuf_d;
   logic [31:0] dinst_q, dinst_d;
   logic [31:0] dpc4_q, dpc4_d;
   logic        dvalid_q, dvalid_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        unused_pcsource;

   assign unused_pcsource = pcsource[2];
   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = (pcsource[1:0] != 2'b00) && !stall;

   always_comb begin
      target = pc_plus4;
      case (pcsource[1:0])
         2'b01:   target = bpc;
         2'b10:   target = rpc;
         2'b11:   target = jpc;
         default: target = pc_plus4;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      tgt_d    = tgt_q;
      ibuf_d   = ibuf_q;
      dinst_d  = dinst_q;
      dpc4_d   = dpc4_q;
      dvalid_d = dvalid_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (!stall) begin
               dinst_d  = 32'd0;
               dvalid_d = 1'b0;
            end
         end
         S_REQ: begin
            if (stall) begin
               // Request cannot be aborted; park the word until ID releases the stall.
               if (imem_ack) begin
                  ibuf_d  = imem_rdata;
                  state_d = S_HOLD;
               end
            end else if (imem_ack) begin
               if (redirect) begin
                  dinst_d  = 32'd0;
                  dvalid_d = 1'b0;
                  pc_d     = target;
               end else begin
                  dinst_d  = imem_rdata;
                  dvalid_d = 1'b1;
                  dpc4_d   = pc_plus4;
                  pc_d     = pc_plus4;
               end
            end else begin
               dinst_d  = 32'd0;
               dvalid_d = 1'b0;
               if (redirect) begin
                  tgt_d   = target;
                  state_d = S_DROP;
               end
            end
         end
         S_HOLD: begin
            if (!stall) begin
               state_d = S_REQ;
               if (redirect) begin
                  dinst_d  = 32'd0;
                  dvalid_d = 1'b0;
                  pc_d     = target;
               end else begin
                  dinst_d  = ibuf_q;
                  dvalid_d = 1'b1;
                  dpc4_d   = pc_plus4;
                  pc_d     = pc_plus4;
               end
            end
         end
         S_DROP: begin
            if (!stall) begin
               dinst_d  = 32'd0;
               dvalid_d = 1'b0;
            end
            if (redirect) begin
               tgt_d = target;
            end
            // A redirect in the ack cycle is newer than the stored target.
            if (imem_ack) begin
               pc_d    = redirect ? target : tgt_q;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         tgt_q    <= 32'd0;
         ibuf_q   <= 32'd0;
         dinst_q  <= 32'd0;
         dpc4_q   <= 32'd0;
         dvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         tgt_q    <= tgt_d;
         ibuf_q   <= ibuf_d;
         dinst_q  <= dinst_d;
         dpc4_q   <= dpc4_d;
         dvalid_q <= dvalid_d;
      end
   end

   assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign Dinst     = dinst_q;
   assign Dpc4      = dpc4_q;
   assign Dvalid    = dvalid_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// tb/tb_pipe_if_stage.sv - directed vector bench for pipe_if_stage
// Two instances: RESET_PC=0 for the main vector table, RESET_PC=0xFFFF_FFFC for wrap/reset.
module tb_pipe_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [2:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic        imem_ack;

   logic        req_a, req_b;
   logic [31:0] addr_a, addr_b, rdata_a, rdata_b, pc_a, pc_b;
   logic [31:0] dpc4_a, dpc4_b, dinst_a, dinst_b;
   logic        dvalid_a, dvalid_b;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] JB = 32'h0BAD_0B00;
   localparam logic [31:0] JR = 32'h0BAD_0F00;
   localparam logic [31:0] JJ = 32'h0BAD_0A00;

   always #5 clk = ~clk;

   assign rdata_a = addr_a | 32'hA000_0000;
   assign rdata_b = addr_b | 32'hA000_0000;

   pipe_if_stage #(.RESET_PC(32'h0000_0000)) dut_a (
      .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource),
      .bpc(bpc), .rpc(rpc), .jpc(jpc),
      .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_rdata(rdata_a),
      .pc(pc_a), .Dpc4(dpc4_a), .Dinst(dinst_a), .Dvalid(dvalid_a)
   );

   pipe_if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource),
      .bpc(bpc), .rpc(rpc), .jpc(jpc),
      .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_rdata(rdata_b),
      .pc(pc_b), .Dpc4(dpc4_b), .Dinst(dinst_b), .Dvalid(dvalid_b)
   );

   typedef struct {
      logic        stall;
      logic [2:0]  pcs;
      logic        ack;
      logic [31:0] b, r, j;
      logic        req;
      logic [31:0] addr;
      logic [31:0] dinst;
      logic        dvalid;
      logic [31:0] dpc4;
   } vec_t;

   function automatic vec_t mk(logic s, logic [2:0] p, logic a, logic [31:0] b, logic [31:0] r,
                               logic [31:0] j, logic q, logic [31:0] ad, logic [31:0] di,
                               logic dv, logic [31:0] d4);
      vec_t v;
      v.stall = s; v.pcs = p; v.ack = a; v.b = b; v.r = r; v.j = j;
      v.req = q; v.addr = ad; v.dinst = di; v.dvalid = dv; v.dpc4 = d4;
      return v;
   endfunction

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", name, tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input int tag, input logic q, input logic [31:0] ad, input logic [31:0] di,
                        input logic dv, input logic [31:0] d4);
      chk("b_req",    tag, {31'd0, req_b},    {31'd0, q});
      chk("b_addr",   tag, addr_b,            ad);
      chk("b_pc",     tag, pc_b,              ad);
      chk("b_dinst",  tag, dinst_b,           di);
      chk("b_dvalid", tag, {31'd0, dvalid_b}, {31'd0, dv});
      chk("b_dpc4",   tag, dpc4_b,            d4);
   endtask

   vec_t vt[28];

   initial begin
      vt[0]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h000, 32'h0,         0, 32'h000);
      vt[1]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h004, 32'hA000_0000, 1, 32'h004);
      vt[2]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h008, 32'hA000_0004, 1, 32'h008);
      vt[3]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h00C, 32'hA000_0008, 1, 32'h00C);
      vt[4]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h010, 32'hA000_000C, 1, 32'h010);
      vt[5]  = mk(1, 3'd0, 1, JB, JR, JJ,          0, 32'h010, 32'hA000_000C, 1, 32'h010);
      vt[6]  = mk(1, 3'd1, 1, 32'h777, JR, JJ,     0, 32'h010, 32'hA000_000C, 1, 32'h010);
      vt[7]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h014, 32'hA000_0010, 1, 32'h014);
      vt[8]  = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h018, 32'hA000_0014, 1, 32'h018);
      vt[9]  = mk(0, 3'd5, 1, 32'h100, JR, JJ,     1, 32'h100, 32'h0,         0, 32'h018);
      vt[10] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h104, 32'hA000_0100, 1, 32'h104);
      vt[11] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h108, 32'hA000_0104, 1, 32'h108);
      vt[12] = mk(0, 3'd1, 1, 32'h040, JR, JJ,     1, 32'h040, 32'h0,         0, 32'h108);
      vt[13] = mk(0, 3'd3, 0, JB, JR, 32'h200,     1, 32'h040, 32'h0,         0, 32'h108);
      vt[14] = mk(0, 3'd0, 0, JB, JR, JJ,          1, 32'h040, 32'h0,         0, 32'h108);
      vt[15] = mk(0, 3'd0, 0, JB, JR, JJ,          1, 32'h040, 32'h0,         0, 32'h108);
      vt[16] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h200, 32'h0,         0, 32'h108);
      vt[17] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h204, 32'hA000_0200, 1, 32'h204);
      vt[18] = mk(1, 3'd2, 1, JB, 32'h03C, JJ,     0, 32'h204, 32'hA000_0200, 1, 32'h204);
      vt[19] = mk(0, 3'd2, 1, JB, 32'h03C, JJ,     1, 32'h03C, 32'h0,         0, 32'h204);
      vt[20] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h040, 32'hA000_003C, 1, 32'h040);
      vt[21] = mk(0, 3'd1, 0, 32'h300, JR, JJ,     1, 32'h040, 32'h0,         0, 32'h040);
      vt[22] = mk(0, 3'd3, 0, JB, JR, 32'h400,     1, 32'h040, 32'h0,         0, 32'h040);
      vt[23] = mk(0, 3'd2, 1, JB, 32'h500, JJ,     1, 32'h500, 32'h0,         0, 32'h040);
      vt[24] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h504, 32'hA000_0500, 1, 32'h504);
      vt[25] = mk(1, 3'd0, 0, JB, JR, JJ,          1, 32'h504, 32'hA000_0500, 1, 32'h504);
      vt[26] = mk(0, 3'd0, 0, JB, JR, JJ,          1, 32'h504, 32'h0,         0, 32'h504);
      vt[27] = mk(0, 3'd0, 1, JB, JR, JJ,          1, 32'h508, 32'hA000_0504, 1, 32'h508);

      rst = 1'b1; stall = 1'b0; pcsource = 3'd0; bpc = JB; rpc = JR; jpc = JJ; imem_ack = 1'b1;
      step();
      step();
      chk("rst_req",    0, {31'd0, req_a},    32'd0);
      chk("rst_addr",   0, addr_a,            32'h0);
      chk("rst_dinst",  0, dinst_a,           32'h0);
      chk("rst_dvalid", 0, {31'd0, dvalid_a}, 32'd0);
      chk("rst_dpc4",   0, dpc4_a,            32'h0);
      chk_b(100, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);

      rst = 1'b0;
      for (int i = 0; i < 28; i++) begin
         stall = vt[i].stall; pcsource = vt[i].pcs; imem_ack = vt[i].ack;
         bpc = vt[i].b; rpc = vt[i].r; jpc = vt[i].j;
         step();
         chk("req",    i, {31'd0, req_a},    {31'd0, vt[i].req});
         chk("addr",   i, addr_a,            vt[i].addr);
         chk("pc",     i, pc_a,              vt[i].addr);
         chk("dinst",  i, dinst_a,           vt[i].dinst);
         chk("dvalid", i, {31'd0, dvalid_a}, {31'd0, vt[i].dvalid});
         chk("dpc4",   i, dpc4_a,            vt[i].dpc4);
      end

      // Wrap-around from RESET_PC=0xFFFF_FFFC, then reset taken while in S_DROP.
      rst = 1'b1; stall = 1'b0; pcsource = 3'd0; bpc = JB; rpc = JR; jpc = JJ; imem_ack = 1'b1;
      step();
      chk_b(101, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;
      step();
      chk_b(102, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
      step();
      chk_b(103, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 32'h0);
      step();
      chk_b(104, 1'b1, 32'h0000_0004, 32'hA000_0000, 1'b1, 32'h4);
      imem_ack = 1'b0; pcsource = 3'd1; bpc = 32'h80;
      step();
      chk_b(105, 1'b1, 32'h0000_0004, 32'h0, 1'b0, 32'h4);
      pcsource = 3'd0; bpc = JB;
      step();
      chk_b(106, 1'b1, 32'h0000_0004, 32'h0, 1'b0, 32'h4);
      rst = 1'b1;
      step();
      chk_b(107, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
      chk("a_rst_addr", 107, addr_a,  32'h0);
      chk("a_rst_dpc4", 107, dpc4_a,  32'h0);
      rst = 1'b0; imem_ack = 1'b1;
      step();
      chk_b(108, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
